// File: rtl/intr_consumer_pkg.sv
// Shared constants and the service-engine state encoding.
package intr_consumer_pkg;

  localparam int DATA_W      = 8;
  localparam int DEF_DEPTH   = 4;
  localparam int DEF_TIMEOUT = 15;
  localparam int DEF_CNT_W   = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK      = 2'd1,
    WAIT_CLR = 2'd2
  } state_e;

endpackage

// File: rtl/intr_consumer_if.sv
// Interrupt request/ack bus, drained-data stream and status outputs.
interface intr_consumer_if
  import intr_consumer_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) ();

  logic              intr;
  logic [DATA_W-1:0] din;
  logic              intr_ack;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  irq_count;
  logic              stuck_err;

  // Consumer side (the service engine)
  modport slave (
    input  intr, din, out_ready,
    output intr_ack, out_data, out_valid, irq_count, stuck_err
  );

  // Peripheral / downstream side
  modport master (
    output intr, din, out_ready,
    input  intr_ack, out_data, out_valid, irq_count, stuck_err
  );

endinterface

// File: rtl/intr_consumer_sync_fifo.sv
// Small synchronous FIFO; head is read combinationally from storage.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [DATA_W-1:0]            push_data,
  input  logic                         pop,
  output logic [DATA_W-1:0]            head,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr;
  logic [AW-1:0]     r_rd;
  logic [CW-1:0]     r_count;
  logic              w_push;
  logic              w_pop;

  // Full/empty come from the pre-edge count, so a same-cycle pop never
  // makes room for that cycle's push.
  assign empty  = (r_count == '0);
  assign full   = (r_count == CW'(DEPTH));
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;
  assign count  = r_count;
  assign head   = empty ? '0 : r_mem[r_rd];

  // Storage write; data words carry no reset
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= push_data;
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/intr_consumer.sv
// Interrupt service engine: capture din on a pending intr, pulse intr_ack,
// wait for intr to drop (retrying the ack on a stuck request).
module intr_consumer
  import intr_consumer_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic            clk,
  input  logic            reset,
  intr_consumer_if.slave  bus
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_ACK  = ACK;
  localparam logic [1:0] S_WAIT = WAIT_CLR;
  localparam int         TW     = $clog2(TIMEOUT+1);
  localparam int         CW     = $clog2(DEPTH+1);

  logic [1:0]        r_state;
  logic [1:0]        w_next;
  logic              r_ack;
  logic [TW-1:0]     r_tmo;
  logic [TW-1:0]     w_tmo_inc;
  logic              w_tmo_hit;
  logic [CNT_W-1:0]  r_irq_count;
  logic              r_stuck;
  logic              w_push;
  logic              w_full;
  logic              w_empty;
  logic [DATA_W-1:0] w_head;
  logic [CW-1:0]     w_count;
  logic              w_unused_count;

  assign w_push         = (r_state == S_IDLE) & bus.intr & ~w_full;
  assign w_tmo_inc      = r_tmo + 1'b1;
  assign w_tmo_hit      = (w_tmo_inc == TW'(TIMEOUT));
  assign w_unused_count = ^w_count;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .push_data (bus.din),
    .pop       (bus.out_ready),
    .head      (w_head),
    .empty     (w_empty),
    .full      (w_full),
    .count     (w_count)
  );

  // Next-state decode for the IDLE -> ACK -> WAIT_CLR service loop
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_push) w_next = S_ACK;
      S_ACK:   w_next = S_WAIT;
      S_WAIT:  begin
        if (!bus.intr)      w_next = S_IDLE;
        else if (w_tmo_hit) w_next = S_ACK;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register; intr_ack is registered so it is high exactly in ACK
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ack   <= (w_next == S_ACK);
    end
  end

  // Cycles spent in WAIT_CLR with intr still high; cleared on every ack
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tmo <= '0;
    end else if (r_state == S_ACK) begin
      r_tmo <= '0;
    end else if ((r_state == S_WAIT) && bus.intr) begin
      r_tmo <= w_tmo_inc;
    end
  end

  // Serviced-interrupt count; retries are not counted, wraps silently
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      r_irq_count <= '0;
    else if (w_push) r_irq_count <= r_irq_count + 1'b1;
  end

  // Sticky stuck-interrupt flag, cleared only by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_stuck <= 1'b0;
    else if ((r_state == S_WAIT) && bus.intr && w_tmo_hit) r_stuck <= 1'b1;
  end

  assign bus.intr_ack  = r_ack;
  assign bus.out_data  = w_head;
  assign bus.out_valid = ~w_empty;
  assign bus.irq_count = r_irq_count;
  assign bus.stuck_err = r_stuck;

endmodule

// File: tb/tb_intr_consumer.sv
// Bench for intr_consumer: cycle-level behavioural model plus a data
// scoreboard drained by an independent monitor.
module tb_intr_consumer;
  import intr_consumer_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 15;
  localparam int CNT_W   = 16;
  localparam int M_IDLE  = 0;
  localparam int M_ACK   = 1;
  localparam int M_WAIT  = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  intr_consumer_if #(.CNT_W(CNT_W)) bus ();

  intr_consumer #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state (after the most recent clock edge)
  int               m_st;
  int               m_cnt;
  int               m_tmo;
  logic [CNT_W-1:0] m_irq;
  logic             m_stuck;
  logic [7:0]       exp_q [$];
  logic             last_ack;
  logic [7:0]       mon_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st    = M_IDLE;
    m_cnt   = 0;
    m_tmo   = 0;
    m_irq   = '0;
    m_stuck = 1'b0;
    exp_q.delete();
  endtask

  // Apply one clock edge's worth of rules using the inputs now on the bus
  task automatic model_step();
    int  pre_cnt;
    bit  pop;
    pre_cnt = m_cnt;
    pop     = (pre_cnt > 0) && bus.out_ready;
    case (m_st)
      M_IDLE: if (bus.intr && pre_cnt < DEPTH) begin
        exp_q.push_back(bus.din);
        m_cnt++;
        m_irq = m_irq + 1'b1;
        m_st  = M_ACK;
      end
      M_ACK: begin
        m_st  = M_WAIT;
        m_tmo = 0;
      end
      default: begin
        if (!bus.intr) m_st = M_IDLE;
        else begin
          m_tmo++;
          if (m_tmo == TIMEOUT) begin
            m_stuck = 1'b1;
            m_st    = M_ACK;
          end
        end
      end
    endcase
    if (pop) m_cnt--;
  endtask

  task automatic check_outputs();
    chk("intr_ack",  bus.intr_ack,  (m_st == M_ACK));
    chk("out_valid", bus.out_valid, (m_cnt > 0));
    chk("irq_count", bus.irq_count, m_irq);
    chk("stuck_err", bus.stuck_err, m_stuck);
  endtask

  // Drive inputs just after an edge, check and step the model mid-cycle
  task automatic cycle(input logic ii, input logic [7:0] dd, input logic rr);
    @(posedge clk);
    #1;
    bus.intr      = ii;
    bus.din       = dd;
    bus.out_ready = rr;
    @(negedge clk);
    check_outputs();
    last_ack = bus.intr_ack;
    model_step();
  endtask

  task automatic do_reset(input int n, input logic ii, input logic [7:0] dd);
    @(posedge clk);
    #1;
    reset         = 1'b0;
    bus.intr      = ii;
    bus.din       = dd;
    bus.out_ready = 1'b0;
    #1;
    model_reset();
    check_outputs();
    chk("out_data_rst", bus.out_data, 8'h00);
    repeat (n) begin
      @(negedge clk);
      check_outputs();
      chk("out_data_rst", bus.out_data, 8'h00);
    end
    @(negedge clk);
    reset    = 1'b1;
    last_ack = 1'b0;
    model_step();
  endtask

  // Raise intr with d until acknowledged, then drop it (peripheral behaviour)
  task automatic service(input logic [7:0] d, input logic rr);
    int n;
    n = 0;
    cycle(1'b1, d, rr);
    while (!last_ack && n < 20) begin
      cycle(1'b1, d, rr);
      n++;
    end
    chk("service_ack", last_ack, 1'b1);
    cycle(1'b0, 8'h00, rr);
  endtask

  // Monitor: every accepted word must match the next expected capture
  always @(negedge clk) begin
    if (reset && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got %0h expected none", bus.out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("out_data", bus.out_data, mon_exp);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CNT_W-1:0] irq0;
    logic             p_pend;
    logic [7:0]       p_din;
    logic             acked;
    logic             rr;
    int               hold;

    bus.intr      = 1'b1;
    bus.din       = 8'h50;
    bus.out_ready = 1'b0;
    last_ack      = 1'b0;
    model_reset();

    // Reset held with a pending interrupt
    do_reset(3, 1'b1, 8'h50);

    // Single interrupt (already pending from reset release)
    service(8'h50, 1'b0);
    chk("single_head", bus.out_data, 8'h50);
    chk("single_irq",  bus.irq_count, 1);
    repeat (2) cycle(1'b0, 8'h00, 1'b1);

    // FIFO full back-pressure
    irq0 = m_irq;
    service(8'h24, 1'b0);
    service(8'h30, 1'b0);
    service(8'h40, 1'b0);
    service(8'hDB, 1'b0);
    repeat (3) cycle(1'b1, 8'h60, 1'b0);
    cycle(1'b1, 8'h60, 1'b1);
    service(8'h60, 1'b0);
    chk("full_irq", bus.irq_count, irq0 + 5);
    repeat (6) cycle(1'b0, 8'h00, 1'b1);

    // Simultaneous push and pop
    service(8'h11, 1'b0);
    service(8'h22, 1'b0);
    cycle(1'b1, 8'h33, 1'b1);
    cycle(1'b1, 8'h33, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    chk("pushpop_head", bus.out_data, 8'h22);
    repeat (4) cycle(1'b0, 8'h00, 1'b1);

    // Stuck interrupt
    irq0 = m_irq;
    cycle(1'b1, 8'hA5, 1'b0);
    repeat (TIMEOUT + 3) cycle(1'b1, 8'hA5, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    chk("stuck_flag", bus.stuck_err, 1'b1);
    chk("stuck_irq",  bus.irq_count, irq0 + 1);
    chk("stuck_head", bus.out_data, 8'hA5);
    repeat (3) cycle(1'b0, 8'h00, 1'b1);

    // Reset in the ACK cycle
    cycle(1'b1, 8'h77, 1'b0);
    do_reset(1, 1'b1, 8'h50);
    service(8'h50, 1'b0);
    chk("rst_irq",  bus.irq_count, 1);
    chk("rst_head", bus.out_data, 8'h50);

    // Randomised peripheral and downstream
    p_pend = 1'b0;
    p_din  = 8'h00;
    acked  = 1'b0;
    hold   = 0;
    for (int i = 0; i < 1500; i++) begin
      if (!p_pend && $urandom_range(0, 2) == 0) begin
        p_pend = 1'b1;
        p_din  = 8'($urandom);
        acked  = 1'b0;
      end
      rr = ((i % 200) < 60) ? 1'b0 : 1'($urandom_range(0, 1));
      cycle(p_pend, p_din, rr);
      if (p_pend && last_ack && !acked) begin
        acked = 1'b1;
        hold  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 20)) : 0;
      end
      if (p_pend && acked) begin
        if (hold == 0) p_pend = 1'b0;
        else hold--;
      end
    end

    repeat (DEPTH + 4) cycle(1'b0, 8'h00, 1'b1);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
